// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
// Build option: PS2_PARITY_CHECK_EN enables odd-parity checking in ps2_frame_rx.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] PS2_PAUSE = 8'hE1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } frame_state_e;

   typedef logic [8:0] key_code_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 pin conditioning and 11-bit frame receiver delivering one byte per good frame.
// Build option: PS2_PARITY_CHECK_EN adds the odd-parity check and the parity_err strobe.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data
`ifdef PS2_PARITY_CHECK_EN
   ,output logic      parity_err
`endif
);

   localparam int unsigned FiltW = $clog2(FILTER_LEN) + 1;
   localparam int unsigned TimW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
   localparam logic [TimW-1:0]  TimLast  = TimW'(TIMEOUT_CYCLES - 1);

   logic             ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
   logic             filt_q, filt_prev_q;
   logic [FiltW-1:0] fcnt_q;
   logic             fall;

   frame_state_e     state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [7:0]       byte_q, byte_d;
   logic             byte_valid_q, byte_valid_d;
   logic [TimW-1:0]  idle_cnt_q, idle_cnt_d;
   logic             perr_d, perr_s1_q, perr_s2_q;
   logic             parity_ok;
   logic             timeout;

   // Pins idle high, so the synchronizers and filter reset to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ck_s1_q     <= 1'b1;
         ck_s2_q     <= 1'b1;
         dt_s1_q     <= 1'b1;
         dt_s2_q     <= 1'b1;
         filt_q      <= 1'b1;
         filt_prev_q <= 1'b1;
         fcnt_q      <= '0;
      end else begin
         ck_s1_q     <= ps2_clk;
         ck_s2_q     <= ck_s1_q;
         dt_s1_q     <= ps2_data;
         dt_s2_q     <= dt_s1_q;
         filt_prev_q <= filt_q;
         if (ck_s2_q == filt_q) begin
            fcnt_q <= '0;
         end else if (fcnt_q == FiltLast) begin
            filt_q <= ck_s2_q;
            fcnt_q <= '0;
         end else begin
            fcnt_q <= fcnt_q + 1'b1;
         end
      end
   end

   assign fall = filt_prev_q & ~filt_q;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shift_q, par_q};
`else
   logic unused_par;
   assign unused_par = par_q;
   assign parity_ok  = 1'b1;
`endif

   assign timeout = (state_q != IDLE) && (idle_cnt_q >= TimLast) && !fall;

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      byte_d       = byte_q;
      byte_valid_d = 1'b0;
      perr_d       = 1'b0;
      idle_cnt_d   = '0;

      if (fall) begin
         idle_cnt_d = '0;
      end else if (state_q != IDLE) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end

      if (timeout) begin
         state_d = IDLE;
      end else if (fall) begin
         unique case (state_q)
            IDLE: begin
               if (!dt_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {dt_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dt_s2_q;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (dt_s2_q) begin
                  if (parity_ok) begin
                     byte_d       = shift_q;
                     byte_valid_d = 1'b1;
                  end else begin
                     perr_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         byte_q       <= '0;
         byte_valid_q <= 1'b0;
         idle_cnt_q   <= '0;
         perr_s1_q    <= 1'b0;
         perr_s2_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         byte_q       <= byte_d;
         byte_valid_q <= byte_valid_d;
         idle_cnt_q   <= idle_cnt_d;
         // Two stages so the drop strobe lines up with where key_valid would have been.
         perr_s1_q    <= perr_d;
         perr_s2_q    <= perr_s1_q;
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_q;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_err = perr_s2_q;
`else
   logic unused_perr;
   assign unused_perr = perr_s2_q;
`endif

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: make/break/E0 handling, key event strobe and held-key bitmap.
// Build option: PS2_PARITY_CHECK_EN exposes the parity_err strobe.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic         key_valid,
   output logic [8:0]   last_change,
   output logic [511:0] key_down,
   output logic         keydown
`ifdef PS2_PARITY_CHECK_EN
   ,output logic        parity_err
`endif
);

   logic         byte_valid;
   logic [7:0]   byte_data;

   logic         ext_q, ext_d;
   logic         brk_q, brk_d;
   key_code_t    last_q, last_d;
   logic         valid_q, valid_d;
   logic [511:0] down_q, down_d;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frame_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data)
`ifdef PS2_PARITY_CHECK_EN
      ,.parity_err (parity_err)
`endif
   );

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      last_d  = last_q;
      valid_d = 1'b0;
      down_d  = down_q;
      if (byte_valid) begin
         if (byte_data == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (byte_data == PS2_BRK) begin
            brk_d = 1'b1;
         end else if (byte_data != PS2_PAUSE) begin
            last_d                    = {ext_q, byte_data};
            down_d[{ext_q, byte_data}] = ~brk_q;
            valid_d                   = 1'b1;
            ext_d                     = 1'b0;
            brk_d                     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         last_q  <= '0;
         valid_q <= 1'b0;
         down_q  <= '0;
      end else begin
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         down_q  <= down_d;
      end
   end

   assign key_valid   = valid_q;
   assign last_change = last_q;
   assign key_down    = down_q;
   assign keydown     = down_q[last_q];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_key_decoder;

   localparam int unsigned Half    = 40;
   localparam int unsigned Timeout = 2000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ps2_clk = 1'b1;
   logic         ps2_data = 1'b1;
   logic         key_valid;
   logic [8:0]   last_change;
   logic [511:0] key_down;
   logic         keydown;
`ifdef PS2_PARITY_CHECK_EN
   logic         parity_err;
`endif

   int n_vec = 0;
   int n_err = 0;
   int kv_pulses = 0;
   int pe_pulses = 0;
   int kv_base;
   int pe_base;

   ps2_key_decoder #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (Timeout)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .key_valid   (key_valid),
      .last_change (last_change),
      .key_down    (key_down),
      .keydown     (keydown)
`ifdef PS2_PARITY_CHECK_EN
      ,.parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && key_valid) kv_pulses++;
`ifdef PS2_PARITY_CHECK_EN
      if (rst_n && parity_err) pe_pulses++;
`endif
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_clks(Half / 2);
      ps2_clk = 1'b0;
      wait_clks(Half);
      ps2_clk = 1'b1;
      wait_clks(Half / 2);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b) ^ bad_par);
      send_bit(1'b1);
      ps2_data = 1'b1;
      wait_clks(30);
      @(negedge clk);
   endtask

   // Start bit followed by n data bits, leaving the pins idle-high.
   task automatic send_partial(input logic [7:0] b, input int n);
      send_bit(1'b0);
      for (int i = 0; i < n; i++) send_bit(b[i]);
      ps2_data = 1'b1;
   endtask

   initial begin
      wait_clks(3);
      @(negedge clk);
      check_eq("rst_key_valid", 32'(key_valid), 32'd0);
      check_eq("rst_last_change", 32'(last_change), 32'h000);
      check_eq("rst_key_down_any", 32'(|key_down), 32'd0);
      check_eq("rst_keydown", 32'(keydown), 32'd0);
      rst_n = 1'b1;
      wait_clks(5);

      // Make 0x16
      kv_base = kv_pulses;
      send_frame(8'h16, 1'b0);
      check_eq("make_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("make_last", 32'(last_change), 32'h016);
      check_eq("make_down", 32'(key_down[9'h016]), 32'd1);
      check_eq("make_keydown", 32'(keydown), 32'd1);

      // Typematic repeat
      kv_base = kv_pulses;
      send_frame(8'h16, 1'b0);
      check_eq("repeat_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("repeat_down", 32'(key_down[9'h016]), 32'd1);

      // Break F0 16
      kv_base = kv_pulses;
      send_frame(8'hF0, 1'b0);
      check_eq("brk_prefix_pulses", 32'(kv_pulses - kv_base), 32'd0);
      send_frame(8'h16, 1'b0);
      check_eq("break_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("break_last", 32'(last_change), 32'h016);
      check_eq("break_down", 32'(key_down[9'h016]), 32'd0);
      check_eq("break_keydown", 32'(keydown), 32'd0);

      // Extended make E0 75, break E0 F0 75
      kv_base = kv_pulses;
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      check_eq("ext_make_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("ext_make_last", 32'(last_change), 32'h175);
      check_eq("ext_make_down", 32'(key_down[9'h175]), 32'd1);
      check_eq("ext_make_plain_down", 32'(key_down[9'h075]), 32'd0);
      kv_base = kv_pulses;
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      check_eq("ext_break_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("ext_break_last", 32'(last_change), 32'h175);
      check_eq("ext_break_down", 32'(key_down[9'h175]), 32'd0);

      // Break for an unheld key still pulses
      kv_base = kv_pulses;
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check_eq("unheld_break_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("unheld_break_last", 32'(last_change), 32'h01C);
      check_eq("unheld_break_down", 32'(key_down[9'h01C]), 32'd0);

      // E1 is ignored and leaves flags alone
      kv_base = kv_pulses;
      send_frame(8'hE1, 1'b0);
      check_eq("pause_pulses", 32'(kv_pulses - kv_base), 32'd0);
      check_eq("pause_last", 32'(last_change), 32'h01C);
      send_frame(8'h29, 1'b0);
      check_eq("after_pause_last", 32'(last_change), 32'h029);
      check_eq("after_pause_down", 32'(key_down[9'h029]), 32'd1);

      // Bad parity on 0x1E
      kv_base = kv_pulses;
      pe_base = pe_pulses;
      send_frame(8'h1E, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
      check_eq("perr_kv_pulses", 32'(kv_pulses - kv_base), 32'd0);
      check_eq("perr_pulses", 32'(pe_pulses - pe_base), 32'd1);
      check_eq("perr_last", 32'(last_change), 32'h029);
      send_frame(8'h1E, 1'b0);
      check_eq("perr_good_last", 32'(last_change), 32'h01E);
`else
      check_eq("nopar_kv_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("nopar_last", 32'(last_change), 32'h01E);
`endif

      // Timeout discards a partial frame
      kv_base = kv_pulses;
      send_partial(8'h5A, 4);
      wait_clks(Timeout + 500);
      check_eq("timeout_pulses", 32'(kv_pulses - kv_base), 32'd0);
      send_frame(8'h26, 1'b0);
      check_eq("timeout_next_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("timeout_next_last", 32'(last_change), 32'h026);

      // Reset mid-frame with 0x16 held
      send_frame(8'h16, 1'b0);
      check_eq("pre_rst_down", 32'(key_down[9'h016]), 32'd1);
      send_partial(8'h33, 3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_key_valid", 32'(key_valid), 32'd0);
      check_eq("midrst_last", 32'(last_change), 32'h000);
      check_eq("midrst_down_any", 32'(|key_down), 32'd0);
      check_eq("midrst_keydown", 32'(keydown), 32'd0);
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(20);
      kv_base = kv_pulses;
      send_frame(8'h4A, 1'b0);
      check_eq("post_rst_pulses", 32'(kv_pulses - kv_base), 32'd1);
      check_eq("post_rst_last", 32'(last_change), 32'h04A);
      check_eq("post_rst_down", 32'(key_down[9'h04A]), 32'd1);
      check_eq("post_rst_old_down", 32'(key_down[9'h016]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
